// File: rtl/button_debouncer_if.sv
// Button conditioning signal bundle: raw pin in, debounced level and
// qualification flag out.
// Handshake: this is a plain level interface with no valid/ready pair.
// button_raw may change at any time, asynchronously to clk. button_clean
// and bouncing are registered levels that are meaningful on every cycle.
interface button_debouncer_if;
  logic button_raw;
  logic button_clean;
  logic bouncing;

  // Producer of the raw pin and consumer of the conditioned level.
  modport master (
    output button_raw,
    input  button_clean,
    input  bouncing
  );

  // The debouncer itself.
  modport slave (
    input  button_raw,
    output button_clean,
    output bouncing
  );
endinterface

// File: rtl/button_debouncer.sv
// Push-button debouncer. The raw pin first passes through a synchroniser
// chain. A four-state FSM with a stability counter then accepts a level
// change only after DEBOUNCE_CYCLES consecutive identical synchronised
// samples. Any reversal while a change is being qualified drops back to the
// previous stable state and discards the partial count.
module button_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic                clk,
  input  logic                reset,
  button_debouncer_if.slave   btn,
  output logic [1:0]          dbg_state_o
);

  // The encoding is chosen so that bit 1 is the accepted level and
  // bit 0 ^ bit 1 marks a qualification in progress.
  typedef enum logic [1:0] {
    STABLE_LOW  = 2'b00,
    CHECK_HIGH  = 2'b01,
    STABLE_HIGH = 2'b11,
    CHECK_LOW   = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   clean_q, clean_d;
  logic                   bouncing_q, bouncing_d;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Synchroniser chain: a pure shift register with no logic between stages.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn.button_raw};
    end
  end

  // Next-state, counter and output decisions for the qualification FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    case (state_q)
      STABLE_LOW: begin
        if (sync_out) begin
          state_d = CHECK_HIGH;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      CHECK_HIGH: begin
        if (!sync_out) begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HIGH;
          clean_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      STABLE_HIGH: begin
        if (!sync_out) begin
          state_d = CHECK_LOW;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      CHECK_LOW: begin
        if (sync_out) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LOW;
          clean_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = STABLE_LOW;
        cnt_d   = '0;
        clean_d = 1'b0;
      end
    endcase
    bouncing_d = (state_d == CHECK_HIGH) || (state_d == CHECK_LOW);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= STABLE_LOW;
      cnt_q      <= '0;
      clean_q    <= 1'b0;
      bouncing_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clean_q    <= clean_d;
      bouncing_q <= bouncing_d;
    end
  end

  assign btn.button_clean = clean_q;
  assign btn.bouncing     = bouncing_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer. Two instances share the raw pin and
// reset: one with DEBOUNCE_CYCLES=4 for the detailed timing scenarios, and
// one with default parameters for the 18-edge latency and long-filter checks.
module tb_button_debouncer;

  logic       clk;
  logic       reset;
  logic       raw;
  logic [1:0] dbg4, dbg16;

  int total;
  int passed;

  button_debouncer_if if4 ();
  button_debouncer_if if16 ();

  assign if4.button_raw  = raw;
  assign if16.button_raw = raw;

  button_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_W(3)) dut4 (
    .clk         (clk),
    .reset       (reset),
    .btn         (if4.slave),
    .dbg_state_o (dbg4)
  );

  button_debouncer dut16 (
    .clk         (clk),
    .reset       (reset),
    .btn         (if16.slave),
    .dbg_state_o (dbg16)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    logic [5:0]  bpat;
    logic [15:0] bexp;
    logic [2:0]  rpat;
    logic [15:0] rexp;
    logic        prev;
    int          edges;
    int          len;

    total  = 0;
    passed = 0;

    // Reset held for 3 cycles with the button pressed.
    reset = 1'b0;
    raw   = 1'b1;
    #1;
    check("rst_async clean4", if4.button_clean, 0);
    check("rst_async bounce4", if4.bouncing, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("rst clean4 k=%0d", k), if4.button_clean, 0);
      check($sformatf("rst bounce4 k=%0d", k), if4.bouncing, 0);
      check($sformatf("rst clean16 k=%0d", k), if16.button_clean, 0);
      check($sformatf("rst bounce16 k=%0d", k), if16.bouncing, 0);
    end

    // Release between edges; edge k=1 is the first one sampling the pin.
    reset = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      check($sformatf("hold clean16 k=%0d", k), if16.button_clean, 32'(k >= 18));
      check($sformatf("hold bounce16 k=%0d", k), if16.bouncing, 32'(k >= 3 && k <= 17));
      check($sformatf("hold clean4 k=%0d", k), if4.button_clean, 32'(k >= 6));
      check($sformatf("hold bounce4 k=%0d", k), if4.bouncing, 32'(k >= 3 && k <= 5));
    end
    check("hold state4", dbg4, 2'b11);
    check("hold state16", dbg16, 2'b11);

    raw = 1'b0;
    idle(20);
    check("settle clean4", if4.button_clean, 0);
    check("settle clean16", if16.button_clean, 0);
    check("settle state4", dbg4, 2'b00);

    // Clean press: raw high before edge 0, accepted after edge 5.
    raw = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      step();
      check($sformatf("press clean4 k=%0d", k), if4.button_clean, 32'(k >= 5));
      check($sformatf("press bounce4 k=%0d", k), if4.bouncing, 32'(k >= 2 && k <= 4));
    end
    raw = 1'b0;
    idle(12);
    check("press release clean4", if4.button_clean, 0);
    check("press short16 clean16", if16.button_clean, 0);

    // Glitch rejection (3-cycle pulse) and minimum accepted pulse (4 cycles).
    for (int li = 0; li < 2; li++) begin
      len = 3 + li;
      for (int k = 0; k <= len + 8; k++) begin
        raw = (k < len);
        step();
        if (len == 3) begin
          check($sformatf("glitch3 clean4 k=%0d", k), if4.button_clean, 0);
          check($sformatf("glitch3 bounce4 k=%0d", k), if4.bouncing, 32'(k >= 2 && k <= 4));
        end else begin
          check($sformatf("pulse4 clean4 k=%0d", k), if4.button_clean, 32'(k >= 5 && k <= 8));
          check($sformatf("pulse4 bounce4 k=%0d", k), if4.bouncing,
                32'((k >= 2 && k <= 4) || (k >= 6 && k <= 8)));
        end
        check($sformatf("pulse clean16 len=%0d k=%0d", len, k), if16.button_clean, 0);
      end
      raw = 1'b0;
      idle(5);
    end

    // Bouncy press 1,0,1,1,0,1 then held 1: one rise, after edge 10.
    bpat  = 6'b101101;
    bexp  = 16'b0000_0011_1011_0100;
    prev  = if4.button_clean;
    edges = 0;
    for (int k = 0; k <= 13; k++) begin
      raw = (k < 6) ? bpat[k] : 1'b1;
      step();
      check($sformatf("bouncy clean4 k=%0d", k), if4.button_clean, 32'(k >= 10));
      check($sformatf("bouncy bounce4 k=%0d", k), if4.bouncing, 32'(bexp[k]));
      if (if4.button_clean && !prev) edges++;
      prev = if4.button_clean;
    end
    check("bouncy rise count", edges, 1);

    // Release bounce 0,1,0 then held 0: one fall, after edge 7.
    rpat  = 3'b010;
    rexp  = 16'b0000_0000_0111_0100;
    prev  = if4.button_clean;
    edges = 0;
    for (int k = 0; k <= 11; k++) begin
      raw = (k < 3) ? rpat[k] : 1'b0;
      step();
      check($sformatf("release clean4 k=%0d", k), if4.button_clean, 32'(k < 7));
      check($sformatf("release bounce4 k=%0d", k), if4.bouncing, 32'(rexp[k]));
      if (!if4.button_clean && prev) edges++;
      prev = if4.button_clean;
    end
    check("release fall count", edges, 1);

    // Asynchronous reset while qualifying a press with cnt=2.
    idle(10);
    raw = 1'b1;
    for (int k = 0; k <= 3; k++) step();
    check("midrst pre state4", dbg4, 2'b01);
    check("midrst pre bounce4", if4.bouncing, 1);
    #2;
    reset = 1'b0;
    #1;
    check("midrst async bounce4", if4.bouncing, 0);
    check("midrst async clean4", if4.button_clean, 0);
    check("midrst async state4", dbg4, 2'b00);
    check("midrst async bounce16", if16.bouncing, 0);
    for (int k = 0; k < 2; k++) begin
      step();
      check($sformatf("midrst held bounce4 k=%0d", k), if4.bouncing, 0);
    end
    #2;
    reset = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      step();
      check($sformatf("midrst requal clean4 k=%0d", k), if4.button_clean, 32'(k >= 5));
      check($sformatf("midrst requal bounce4 k=%0d", k), if4.bouncing, 32'(k >= 2 && k <= 4));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Upstream conditioning stage for the button one-shot (valid-in) state machine.
- Synchronises the raw, asynchronous, bouncing push-button input into the clk domain.
- Filters bounce and glitches with a stability counter.
- Delivers a clean, glitch-free level `button_clean`, which drives the `button` input of the one-shot stage.

Parameters:
- SYNC_STAGES, 2: number of synchroniser flops on `button_raw`; legal values ≥ 2.
- DEBOUNCE_CYCLES, 16: consecutive identical synchronised samples required to accept a level change; legal values ≥ 2.
- CNT_W, 5: stability counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  single system clock; all flops on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- button_raw  input  1  raw push-button pin; asynchronous, may bounce.
- button_clean  output  1  debounced, synchronised level; feeds the one-shot stage.
- bouncing  output  1  high while a candidate level change is being qualified.

Behaviour:
- Reset
  - reset=0 immediately clears, without waiting for clk: synchroniser chain, counter, state (STABLE_LOW) and all outputs.
  - Reset values: button_clean=0, bouncing=0.
  - Release is sampled on the next clk rising edge; no output changes on the release edge itself.
- Synchroniser
  - SYNC_STAGES-deep flop chain; `sync_out` is the last stage.
  - No logic between stages. The FSM sees only `sync_out`.
- State encoding (2 bits): STABLE_LOW=00, CHECK_HIGH=01, STABLE_HIGH=11, CHECK_LOW=10. Unused codes: none.
- Transitions, evaluated each rising edge:
  - STABLE_LOW: sync_out=1 → CHECK_HIGH, cnt←1. Otherwise stay, cnt←0.
  - CHECK_HIGH:
    - sync_out=0 → STABLE_LOW, cnt←0 (glitch rejected; button_clean stays 0).
    - else if cnt==DEBOUNCE_CYCLES-1 → STABLE_HIGH, button_clean←1, cnt←0.
    - else cnt←cnt+1.
  - STABLE_HIGH: sync_out=0 → CHECK_LOW, cnt←1. Otherwise stay.
  - CHECK_LOW: mirror of CHECK_HIGH.
    - sync_out=1 → STABLE_HIGH, cnt←0.
    - else if cnt==DEBOUNCE_CYCLES-1 → STABLE_LOW, button_clean←0, cnt←0.
    - else cnt←cnt+1.
- Outputs
  - button_clean is a registered flop, changed only on the two accepting transitions above.
  - bouncing is registered and equals 1 exactly while the state is CHECK_HIGH or CHECK_LOW.
- Latency and filtering
  - A level change on button_raw, stable from before rising edge E0, appears on button_clean after edge E0+SYNC_STAGES+DEBOUNCE_CYCLES-1. Defaults: 18 edges.
  - A synchronised pulse of ≥ DEBOUNCE_CYCLES cycles is accepted.
  - A pulse of ≤ DEBOUNCE_CYCLES-1 cycles is rejected, with no button_clean change.
- Bounce handling: any reversal during CHECK_* returns to the prior STABLE_* state. The next qualifying attempt restarts the count from 1; no partial credit is kept.
- Counter: never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- button_clean never toggles on two consecutive cycles. Minimum hold time of each level is DEBOUNCE_CYCLES cycles.
- Mid-operation reset (including during CHECK_*): returns to STABLE_LOW. If button_raw is still high after release, a full qualification is required before button_clean rises again.
- Downstream contract: the one-shot stage sees exactly one 0→1 edge per physical press, regardless of bounce.

Test Plan:
- Reset and hold
  - Stimulus: reset=0 for 3 cycles with button_raw=1, then release.
  - Required: button_clean=0 and bouncing=0 throughout reset. Defaults: button_clean rises on the 18th edge after release.
- Clean press
  - Stimulus: DEBOUNCE_CYCLES=4, SYNC_STAGES=2; button_raw 0→1 before edge 0, held.
  - Required: button_clean=1 after edge 5, not before. bouncing=1 after edges 2–4 only.
- Glitch rejection
  - Stimulus: DEBOUNCE_CYCLES=4; button_raw high for exactly 3 cycles, then low.
  - Required: button_clean stays 0; bouncing pulses for 3 cycles. Repeat with a 4-cycle pulse; required: button_clean rises.
- Bouncy press
  - Stimulus: DEBOUNCE_CYCLES=4; button_raw pattern 1,0,1,1,0,1 then held 1.
  - Required: exactly one button_clean 0→1 transition, occurring 5 edges after the final stable 1 is sampled into the chain.
- Release bounce
  - Stimulus: from STABLE_HIGH, button_raw 0,1,0 then held 0.
  - Required: single 1→0 transition on button_clean; no intermediate re-rise.
- Async reset mid-check
  - Stimulus: assert reset=0 between clock edges while in CHECK_HIGH with cnt=2.
  - Required: bouncing and button_clean read 0 before the next rising edge; the counter restarts from 0 after release.
